serial_sync_tx: RTL and testbench

- Frame transmitter that serializes a parallel payload byte behind a fixed 8-bit sync word on a single-bit line, MSB first, one bit per clock.
- It drives the bit stream that the `mealy` sequence detector consumes; that detector flags the sync pattern `01010101`.
- It sits between a byte-wide producer (valid/ready handshake) and the serial `din` input of the detector.

---
 rtl/serial_sync_pkg.sv | 23 ++
 rtl/serial_sync_tx_piso_shift8.sv | 25 ++
 rtl/serial_sync_tx.sv | 132 +++++++++++++
 tb/tb_serial_sync_tx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sync_pkg.sv
// Shared constants for the sync-word frame transmitter.
package serial_sync_pkg;

  // One-hot FSM encodings
  localparam logic [3:0] IDLE_OH = 4'b0001;
  localparam logic [3:0] SYNC_OH = 4'b0010;
  localparam logic [3:0] DATA_OH = 4'b0100;
  localparam logic [3:0] GAP_OH  = 4'b1000;

  typedef enum logic [3:0] {
    ST_IDLE = IDLE_OH,
    ST_SYNC = SYNC_OH,
    ST_DATA = DATA_OH,
    ST_GAP  = GAP_OH
  } state_e;

  // Pattern the downstream detector looks for
  localparam logic [7:0] SYNC_DEFAULT = 8'b0101_0101;

  // Bit counter spans the 8 bits of one byte (7 down to 0)
  localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/serial_sync_tx_piso_shift8.sv
// 8-bit parallel-in / serial-out register, MSB first.
// Vacated positions and the reset value are FILL so the line idles at FILL.
module piso_shift8 #(
  parameter logic FILL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] d,
  output logic       q_msb
);

  logic [7:0] sr_q;

  // Load has priority over shift; shifting pulls in the fill level
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sr_q <= {8{FILL}};
    else if (load)  sr_q <= d;
    else if (shift) sr_q <= {sr_q[6:0], FILL};
  end

  assign q_msb = sr_q[7];

endmodule

// File: rtl/serial_sync_tx.sv
// Frame transmitter: SYNC word then payload byte, MSB first, followed by
// GAP_LEN idle bit times. dout is the MSB flop of the shift register; between
// frames the register is refilled with the idle level so the line is idle.
module serial_sync_tx
  import serial_sync_pkg::*;
#(
  parameter logic [7:0] SYNC       = SYNC_DEFAULT,
  parameter logic       IDLE_LEVEL = 1'b1,
  parameter int         GAP_LEN    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       load,
  output logic       ready,
  output logic       dout,
  output logic       frame,
  output logic       done,
  output logic [7:0] frame_cnt
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_LEN - 1);

  state_e               state_q;
  logic [BIT_CNT_W-1:0] cnt_q;
  logic [3:0]           gap_q;
  logic [7:0]           payload_q;
  logic                 ready_q, frame_q, done_q;
  logic [7:0]           frame_cnt_q;

  logic       accept;
  logic       sr_load, sr_shift;
  logic [7:0] sr_d;

  assign accept = load & ready_q;

  // Shift register control: load sync/payload/idle fill at phase boundaries,
  // shift while bits of the current byte remain
  always_comb begin
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_d     = {8{IDLE_LEVEL}};
    case (state_q)
      ST_IDLE: if (accept) begin
        sr_load = 1'b1;
        sr_d    = SYNC;
      end
      ST_SYNC: if (cnt_q == '0) begin
        sr_load = 1'b1;
        sr_d    = payload_q;
      end else begin
        sr_shift = 1'b1;
      end
      ST_DATA: if (cnt_q == '0) sr_load = 1'b1;
               else             sr_shift = 1'b1;
      ST_GAP:  ;
      default: sr_load = 1'b1;
    endcase
  end

  piso_shift8 #(.FILL(IDLE_LEVEL)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (sr_load),
    .shift (sr_shift),
    .d     (sr_d),
    .q_msb (dout)
  );

  // Frame FSM with bit/gap counters, handshake and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gap_q       <= '0;
      payload_q   <= '0;
      ready_q     <= 1'b1;
      frame_q     <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          state_q   <= ST_SYNC;
          payload_q <= data_in;
          cnt_q     <= '1;
          ready_q   <= 1'b0;
          frame_q   <= 1'b1;
        end
        ST_SYNC: if (cnt_q == '0) begin
          state_q <= ST_DATA;
          cnt_q   <= '1;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        ST_DATA: if (cnt_q == '0) begin
          state_q     <= ST_GAP;
          frame_q     <= 1'b0;
          done_q      <= 1'b1;
          frame_cnt_q <= frame_cnt_q + 8'd1;
          gap_q       <= GAP_LAST;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        ST_GAP: begin
          done_q <= 1'b0;
          if (gap_q == '0) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= '0;
          gap_q       <= '0;
          ready_q     <= 1'b1;
          frame_q     <= 1'b0;
          done_q      <= 1'b0;
          frame_cnt_q <= '0;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign frame     = frame_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_serial_sync_tx.sv
// Bench for serial_sync_tx: two instances (GAP_LEN=2 and GAP_LEN=1) share
// stimulus; each is compared every cycle against a frame-position model, and
// a sliding-window sync detector is modelled on each serial line.
module tb_serial_sync_tx;

  localparam int NDUT = 2;

  logic             clk = 1'b0;
  logic             rst, load;
  logic [7:0]       data_in;
  logic [NDUT-1:0]  ready, dout, frame, done;
  logic [7:0]       frame_cnt [NDUT];

  int n_tests = 0, n_fail = 0, cyc = 0;

  // model state, indexed by instance
  bit         m_busy   [NDUT];
  int         m_j      [NDUT];
  logic [7:0] m_data   [NDUT];
  logic [7:0] m_cnt    [NDUT];
  logic [7:0] hist     [NDUT];
  int         det_cnt  [NDUT];
  int         det_j    [NDUT];
  int         done_seen[NDUT];
  bit         prev_frm [NDUT];
  int         last_rise[NDUT];
  int         spacing  [NDUT];
  logic [17:0] seq0;

  serial_sync_tx #(.GAP_LEN(2)) u_tx_g2 (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load),
    .ready(ready[0]), .dout(dout[0]), .frame(frame[0]), .done(done[0]),
    .frame_cnt(frame_cnt[0]));

  serial_sync_tx #(.GAP_LEN(1)) u_tx_g1 (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load),
    .ready(ready[1]), .dout(dout[1]), .frame(frame[1]), .done(done[1]),
    .frame_cnt(frame_cnt[1]));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic int gap_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      m_busy[i] = 0; m_j[i] = 0; m_cnt[i] = 8'd0; hist[i] = 8'hFF;
      prev_frm[i] = 0; last_rise[i] = -1000;
    end
  endtask

  // Reset asserted between clock edges; outputs must react immediately
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("rst_dout%0d", i),  dout[i],      1);
      chk($sformatf("rst_ready%0d", i), ready[i],     1);
      chk($sformatf("rst_frame%0d", i), frame[i],     0);
      chk($sformatf("rst_done%0d", i),  done[i],      0);
      chk($sformatf("rst_cnt%0d", i),   frame_cnt[i], 0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // One clock: advance the model at the edge, compare at the falling edge
  task automatic tick();
    bit         acc;
    int         j;
    logic [15:0] fr;
    logic       e_dout, e_frame, e_done, e_ready;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NDUT; i++) begin
      acc = load && !m_busy[i];
      if (m_busy[i]) begin
        m_j[i]++;
        if (m_j[i] == 16) m_cnt[i]++;
        if (m_j[i] == 16 + gap_of(i)) m_busy[i] = 0;
      end
      if (acc) begin
        m_busy[i] = 1; m_j[i] = 0; m_data[i] = data_in;
      end
    end
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      j  = m_j[i];
      fr = {8'h55, m_data[i]};
      e_dout = 1'b1; e_frame = 1'b0; e_done = 1'b0; e_ready = !m_busy[i];
      if (m_busy[i]) begin
        if (j < 16) begin e_dout = fr[15-j]; e_frame = 1'b1; end
        e_done = (j == 16);
      end
      chk($sformatf("dout%0d", i),  dout[i],      e_dout);
      chk($sformatf("frame%0d", i), frame[i],     e_frame);
      chk($sformatf("done%0d", i),  done[i],      e_done);
      chk($sformatf("ready%0d", i), ready[i],     e_ready);
      chk($sformatf("fcnt%0d", i),  frame_cnt[i], m_cnt[i]);
      // detector: flag when the previous 8 line bits equal the sync word
      if (hist[i] == 8'h55) begin det_cnt[i]++; det_j[i] = m_j[i]; end
      hist[i] = {hist[i][6:0], dout[i]};
      if (done[i] === 1'b1) done_seen[i]++;
      if (frame[i] === 1'b1 && !prev_frm[i]) begin
        spacing[i] = cyc - last_rise[i];
        last_rise[i] = cyc;
      end
      prev_frm[i] = (frame[i] === 1'b1);
    end
    seq0 = {seq0[16:0], dout[0]};
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send_one(input logic [7:0] b);
    load = 1'b1; data_in = b;
    for (int i = 0; i < NDUT; i++) det_cnt[i] = 0;
    tick();
    load = 1'b0;
  endtask

  initial begin
    bit got;
    rst = 1'b0; load = 1'b0; data_in = 8'h00; seq0 = '0;
    for (int i = 0; i < NDUT; i++) begin
      det_cnt[i] = 0; det_j[i] = -1; done_seen[i] = 0; spacing[i] = 0;
    end
    model_reset();
    do_reset();
    run(3);

    // single frame 0xA3: explicit line sequence and one detection at k+8
    send_one(8'hA3);
    run(17);
    chk("a3_seq", seq0, 18'b010101011010001111);
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("a3_det%0d", i),    det_cnt[i], 1);
      chk($sformatf("a3_det_at%0d", i), det_j[i],   8);
    end
    run(4);

    // overlapping payload 0x55: five detections on alternate cycles
    send_one(8'h55);
    run(22);
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("ovl_det%0d", i),    det_cnt[i], 5);
      chk($sformatf("ovl_last_at%0d", i), det_j[i],  16);
    end

    // busy load: 0x0F held while busy, 0xF0 once ready rises on instance 0
    load = 1'b1; data_in = 8'h3C;
    tick();
    data_in = 8'h0F;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      if (ready[0] === 1'b1) got = 1;
    end
    chk("busy_ready_seen", got, 1);
    data_in = 8'hF0;
    tick();
    load = 1'b0;
    chk("busy_spacing0", spacing[0], 19);
    chk("busy_spacing1", spacing[1], 18);
    chk("busy_payload0", m_data[0], 8'hF0);
    run(40);

    // abort mid-payload, then a clean frame
    send_one(8'h96);
    run(10);
    for (int i = 0; i < NDUT; i++) done_seen[i] = 0;
    do_reset();
    run(20);
    for (int i = 0; i < NDUT; i++) chk($sformatf("abort_nodone%0d", i), done_seen[i], 0);
    send_one(8'hC5);
    run(22);
    for (int i = 0; i < NDUT; i++) chk($sformatf("post_abort_done%0d", i), done_seen[i], 1);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      load    = ($urandom_range(0, 3) == 0);
      data_in = 8'($urandom);
      tick();
    end
    load = 1'b0;
    run(25);

    // 256 back-to-back frames: counter wrap and spacing per GAP_LEN
    do_reset();
    for (int i = 0; i < NDUT; i++) done_seen[i] = 0;
    load = 1'b1;
    for (int k = 0; k < 256 * 19 + 60 && (done_seen[0] < 256 || done_seen[1] < 256); k++) begin
      data_in = 8'($urandom);
      tick();
      for (int i = 0; i < NDUT; i++) begin
        if (done[i] === 1'b1 && done_seen[i] == 255) chk($sformatf("wrap255_%0d", i), frame_cnt[i], 255);
        if (done[i] === 1'b1 && done_seen[i] == 256) chk($sformatf("wrap0_%0d", i),   frame_cnt[i], 0);
      end
    end
    load = 1'b0;
    for (int i = 0; i < NDUT; i++) chk($sformatf("wrap_frames%0d", i), (done_seen[i] >= 256), 1);
    chk("wrap_spacing0", spacing[0], 19);
    chk("wrap_spacing1", spacing[1], 18);
    run(25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
